// File: rtl/mcpu_regfile_wb_sequencer.sv
// Write-port sequencer for MCPU_Registerfile: clears every register after reset, then
// arbitrates ALU / load / move writes round-robin as one regsetwb pulse per two cycles.
module mcpu_regfile_wb_sequencer #(
    parameter int unsigned WORD_SIZE          = 8,
    parameter int unsigned OPERAND_SIZE       = 3,
    parameter int unsigned REGISTERS_NUMBER   = 8,
    parameter logic [1:0]  CMD_NORMAL_EX      = 2'b00,
    parameter logic [1:0]  CMD_LOAD_FROM_DATA = 2'b01,
    parameter logic [1:0]  CMD_MOV_INTERNAL   = 2'b10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_alu_req,
    input  logic [OPERAND_SIZE-1:0] i_alu_dst,
    input  logic [WORD_SIZE-1:0]    i_alu_data,
    output logic                    o_alu_ack,
    input  logic                    i_mem_req,
    input  logic [OPERAND_SIZE-1:0] i_mem_dst,
    input  logic [WORD_SIZE-1:0]    i_mem_data,
    output logic                    o_mem_ack,
    input  logic                    i_mov_req,
    input  logic [OPERAND_SIZE-1:0] i_mov_dst,
    input  logic [OPERAND_SIZE-1:0] i_mov_src,
    output logic                    o_mov_ack,
    input  logic [OPERAND_SIZE-1:0] i_rd_addr_a,
    input  logic [OPERAND_SIZE-1:0] i_rd_addr_b,
    output logic [OPERAND_SIZE-1:0] o_rf_op1,
    output logic [OPERAND_SIZE-1:0] o_rf_op2,
    output logic [OPERAND_SIZE-1:0] o_rf_op3,
    output logic [WORD_SIZE-1:0]    o_rf_data,
    output logic [1:0]              o_rf_cmd,
    output logic                    o_rf_wb,
    output logic                    o_init_done,
    output logic                    o_busy
);

    localparam logic [OPERAND_SIZE-1:0] LastIdx = OPERAND_SIZE'(REGISTERS_NUMBER - 1);

    typedef enum logic [2:0] {StClrIssue, StClrGap, StIdle, StIssue, StGap} state_e;

    // Requester index: 0 = ALU, 1 = MEM, 2 = MOV.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    state_e                  r_state, w_state_nxt;
    logic [OPERAND_SIZE-1:0] r_idx, w_idx_nxt;
    logic [1:0]              r_ptr, w_ptr_nxt;
    logic [OPERAND_SIZE-1:0] r_op1, w_op1_nxt;
    logic [OPERAND_SIZE-1:0] r_src, w_src_nxt;
    logic [WORD_SIZE-1:0]    r_data, w_data_nxt;
    logic [1:0]              r_cmd, w_cmd_nxt;
    logic                    r_wb, w_wb_nxt;
    logic [2:0]              r_ack, w_ack_nxt;
    logic                    r_init_done, w_init_done_nxt;
    logic                    r_busy, w_busy_nxt;

    logic [3:0]              w_req;
    logic [1:0]              w_cand;
    logic [1:0]              w_gnt_idx;
    logic                    w_gnt_vld;

    assign w_req = {1'b0, i_mov_req, i_mem_req, i_alu_req};

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_ptr;
        w_cand    = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!w_gnt_vld && w_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
            w_cand = rr_next(w_cand);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_ptr_nxt       = r_ptr;
        w_op1_nxt       = r_op1;
        w_src_nxt       = r_src;
        w_data_nxt      = r_data;
        w_cmd_nxt       = r_cmd;
        w_wb_nxt        = 1'b0;
        w_ack_nxt       = 3'b000;
        w_init_done_nxt = r_init_done;
        unique case (r_state)
            StClrIssue: begin
                w_wb_nxt    = 1'b1;
                w_cmd_nxt   = CMD_LOAD_FROM_DATA;
                w_op1_nxt   = r_idx;
                w_data_nxt  = '0;
                w_state_nxt = StClrGap;
            end
            StClrGap: begin
                if (r_idx == LastIdx) begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = StIdle;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = StClrIssue;
                end
            end
            StIdle, StGap: begin
                w_state_nxt = StIdle;
                if (w_gnt_vld) begin
                    // Outputs are registered, so the grant decision loads them for ISSUE.
                    w_state_nxt = StIssue;
                    w_wb_nxt    = 1'b1;
                    w_ptr_nxt   = rr_next(w_gnt_idx);
                    unique case (w_gnt_idx)
                        2'd0: begin
                            w_op1_nxt  = i_alu_dst;
                            w_data_nxt = i_alu_data;
                            w_cmd_nxt  = CMD_NORMAL_EX;
                            w_ack_nxt  = 3'b001;
                        end
                        2'd1: begin
                            w_op1_nxt  = i_mem_dst;
                            w_data_nxt = i_mem_data;
                            w_cmd_nxt  = CMD_LOAD_FROM_DATA;
                            w_ack_nxt  = 3'b010;
                        end
                        2'd2: begin
                            w_op1_nxt  = i_mov_dst;
                            w_src_nxt  = i_mov_src;
                            w_cmd_nxt  = CMD_MOV_INTERNAL;
                            w_ack_nxt  = 3'b100;
                        end
                        default: ;
                    endcase
                end
            end
            StIssue: w_state_nxt = StGap;
            default: w_state_nxt = StClrIssue;
        endcase
        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StClrIssue;
            r_idx       <= '0;
            r_ptr       <= 2'd0;
            r_op1       <= '0;
            r_src       <= '0;
            r_data      <= '0;
            r_cmd       <= CMD_NORMAL_EX;
            r_wb        <= 1'b0;
            r_ack       <= 3'b000;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_op1       <= w_op1_nxt;
            r_src       <= w_src_nxt;
            r_data      <= w_data_nxt;
            r_cmd       <= w_cmd_nxt;
            r_wb        <= w_wb_nxt;
            r_ack       <= w_ack_nxt;
            r_init_done <= w_init_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_alu_ack   = r_ack[0];
    assign o_mem_ack   = r_ack[1];
    assign o_mov_ack   = r_ack[2];
    assign o_rf_op1    = r_op1;
    assign o_rf_data   = r_data;
    assign o_rf_cmd    = r_cmd;
    assign o_rf_wb     = r_wb;
    assign o_init_done = r_init_done;
    assign o_busy      = r_busy;

    // A MOV keeps its source on op2 through its whole ISSUE/GAP slot.
    assign o_rf_op2 = ((r_state == StIssue || r_state == StGap) && r_cmd == CMD_MOV_INTERNAL)
                      ? r_src : i_rd_addr_a;
    assign o_rf_op3 = i_rd_addr_b;

endmodule

// File: tb/tb_mcpu_regfile_wb_sequencer.sv
// Directed bench for mcpu_regfile_wb_sequencer: clear sequence, grants, round-robin,
// MOV op2 ownership and mid-operation reset, with a write scoreboard checked on rf_wb.
module tb_mcpu_regfile_wb_sequencer;

    typedef struct packed {
        logic [2:0] op1;
        logic [7:0] data;
        logic [1:0] cmd;
        logic [2:0] ack;
        logic       chk_data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_req, mem_req, mov_req;
    logic [2:0] alu_dst, mem_dst, mov_dst, mov_src, rd_a, rd_b;
    logic [7:0] alu_data, mem_data;
    logic       alu_ack, mem_ack, mov_ack;
    logic [2:0] rf_op1, rf_op2, rf_op3;
    logic [7:0] rf_data;
    logic [1:0] rf_cmd;
    logic       rf_wb, init_done, busy;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t m_exp;

    always #5 clk = ~clk;

    mcpu_regfile_wb_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_alu_req  (alu_req),
        .i_alu_dst  (alu_dst),
        .i_alu_data (alu_data),
        .o_alu_ack  (alu_ack),
        .i_mem_req  (mem_req),
        .i_mem_dst  (mem_dst),
        .i_mem_data (mem_data),
        .o_mem_ack  (mem_ack),
        .i_mov_req  (mov_req),
        .i_mov_dst  (mov_dst),
        .i_mov_src  (mov_src),
        .o_mov_ack  (mov_ack),
        .i_rd_addr_a(rd_a),
        .i_rd_addr_b(rd_b),
        .o_rf_op1   (rf_op1),
        .o_rf_op2   (rf_op2),
        .o_rf_op3   (rf_op3),
        .o_rf_data  (rf_data),
        .o_rf_cmd   (rf_cmd),
        .o_rf_wb    (rf_wb),
        .o_init_done(init_done),
        .o_busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op1, input logic [7:0] data, input logic [1:0] cmd,
                        input logic [2:0] ack, input logic chk_data);
        sb.push_back('{op1: op1, data: data, cmd: cmd, ack: ack, chk_data: chk_data});
    endtask

    task automatic push_clear();
        for (int i = 0; i < 8; i++) push(3'(i), 8'h00, 2'b01, 3'b000, 1'b1);
    endtask

    // Entered with reset just released; covers the 16 clear cycles.
    task automatic run_clear();
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk("clr_wb", 32'(rf_wb), 32'(c % 2 == 1));
            chk("clr_init_done", 32'(init_done), 32'(c == 16));
        end
        chk("clr_busy_idle", 32'(busy), 32'd0);
    endtask

    // Every write pulse must match the next scoreboard entry; acks only with a write.
    always @(negedge clk) begin
        if (rf_wb) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $error("FAIL sb_unexpected_wb: got write op1=%0h, expected no write", rf_op1);
            end else begin
                m_exp = sb.pop_front();
                chk("sb_op1", 32'(rf_op1), 32'(m_exp.op1));
                chk("sb_cmd", 32'(rf_cmd), 32'(m_exp.cmd));
                chk("sb_ack", 32'({mov_ack, mem_ack, alu_ack}), 32'(m_exp.ack));
                if (m_exp.chk_data) chk("sb_data", 32'(rf_data), 32'(m_exp.data));
            end
        end else if ({mov_ack, mem_ack, alu_ack} != 3'b000) begin
            chk("ack_without_wb", 32'({mov_ack, mem_ack, alu_ack}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        alu_req  = 1'b0; alu_dst = '0; alu_data = '0;
        mov_req  = 1'b0; mov_dst = '0; mov_src  = '0;
        mem_req  = 1'b1; mem_dst = 3'd4; mem_data = 8'h11;
        rd_a     = 3'd7; rd_b    = 3'd6;
        tick();
        tick();
        chk("rst_wb", 32'(rf_wb), 32'd0);
        chk("rst_cmd", 32'(rf_cmd), 32'd0);
        chk("rst_op1", 32'(rf_op1), 32'd0);
        chk("rst_data", 32'(rf_data), 32'd0);
        chk("rst_acks", 32'({mov_ack, mem_ack, alu_ack}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Clear, with a load request held since reset.
        push_clear();
        push(3'd4, 8'h11, 2'b01, 3'b010, 1'b1);
        reset = 1'b0;
        run_clear();
        tick();
        chk("held_mem_ack", 32'(mem_ack), 32'd1);
        chk("held_mem_op1", 32'(rf_op1), 32'd4);
        mem_req = 1'b0;
        tick();
        tick();

        // Single ALU write.
        alu_req = 1'b1; alu_dst = 3'd3; alu_data = 8'h5A;
        push(3'd3, 8'h5A, 2'b00, 3'b001, 1'b1);
        tick();
        chk("alu_wb", 32'(rf_wb), 32'd1);
        chk("alu_ack", 32'(alu_ack), 32'd1);
        chk("alu_op1", 32'(rf_op1), 32'd3);
        chk("alu_data", 32'(rf_data), 32'h5A);
        chk("alu_cmd", 32'(rf_cmd), 32'd0);
        alu_req = 1'b0;
        tick();
        chk("alu_gap_wb", 32'(rf_wb), 32'd0);
        chk("alu_gap_op1", 32'(rf_op1), 32'd3);
        tick();

        // MOV owns op2 only through its ISSUE/GAP.
        chk("mov_pre_op2", 32'(rf_op2), 32'd7);
        chk("op3_pass", 32'(rf_op3), 32'd6);
        mov_req = 1'b1; mov_dst = 3'd2; mov_src = 3'd5;
        push(3'd2, 8'h00, 2'b10, 3'b100, 1'b0);
        #1;
        chk("mov_req_op2", 32'(rf_op2), 32'd7);
        tick();
        chk("mov_cmd", 32'(rf_cmd), 32'd2);
        chk("mov_op1", 32'(rf_op1), 32'd2);
        chk("mov_issue_op2", 32'(rf_op2), 32'd5);
        chk("mov_ack", 32'(mov_ack), 32'd1);
        mov_req = 1'b0;
        tick();
        chk("mov_gap_op2", 32'(rf_op2), 32'd5);
        chk("mov_gap_wb", 32'(rf_wb), 32'd0);
        tick();
        chk("mov_post_op2", 32'(rf_op2), 32'd7);

        // Three-way contention from pointer = ALU; same destination for ALU and MEM.
        alu_req = 1'b1; alu_dst = 3'd1; alu_data = 8'hA1;
        mem_req = 1'b1; mem_dst = 3'd1; mem_data = 8'hB2;
        mov_req = 1'b1; mov_dst = 3'd6; mov_src  = 3'd0;
        push(3'd1, 8'hA1, 2'b00, 3'b001, 1'b1);
        push(3'd1, 8'hB2, 2'b01, 3'b010, 1'b1);
        push(3'd6, 8'h00, 2'b10, 3'b100, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rr_alu_ack", 32'(alu_ack), 32'(k == 1));
            chk("rr_mem_ack", 32'(mem_ack), 32'(k == 3));
            chk("rr_mov_ack", 32'(mov_ack), 32'(k == 5));
            chk("rr_wb", 32'(rf_wb), 32'(k % 2 == 1));
            if (alu_ack) alu_req = 1'b0;
            if (mem_ack) mem_req = 1'b0;
            if (mov_ack) mov_req = 1'b0;
        end
        tick();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Reset in the middle of an ALU write.
        alu_req = 1'b1; alu_dst = 3'd7; alu_data = 8'hC3;
        push(3'd7, 8'hC3, 2'b00, 3'b001, 1'b1);
        tick();
        chk("rst5_issue_ack", 32'(alu_ack), 32'd1);
        alu_req = 1'b0;
        reset   = 1'b1;
        tick();
        chk("rst5_wb", 32'(rf_wb), 32'd0);
        chk("rst5_acks", 32'({mov_ack, mem_ack, alu_ack}), 32'd0);
        chk("rst5_init_done", 32'(init_done), 32'd0);
        chk("rst5_busy", 32'(busy), 32'd1);
        chk("rst5_sb_drained", 32'(sb.size()), 32'd0);
        push_clear();
        reset = 1'b0;
        run_clear();
        tick();
        tick();
        chk("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
